// File: rtl/activation_arbiter.sv
// Round-robin arbiter that time-shares one Elliot_Activation unit between N_REQ requesters,
// sequencing the unit through clear, start and wait-for-end, with a timeout watchdog.
module activation_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] x_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       y_out,
    output logic                   err,
    output logic                   busy,
    output logic [WIDTH-1:0]       act_x,
    output logic                   act_start,
    output logic                   act_reset,
    input  logic [WIDTH-1:0]       act_y,
    input  logic                   act_end
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  pos;
    logic           any;

    // Round-robin pick: first asserted request at or after ptr, wrapping to 0.
    // NOTE: every always_comb output gets a default before the loop, otherwise a latch is inferred.
    always_comb begin
        sel = '0;
        pos = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = IW'((int'(ptr) + k) % N_REQ);
            if (!any && req[pos]) begin
                any = 1'b1;
                sel = pos;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            y_out     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            act_x     <= '0;
            act_start <= 1'b0;
            act_reset <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    act_reset <= 1'b0;
                    if (any) begin
                        idx       <= sel;
                        act_x     <= x_in[sel*WIDTH +: WIDTH];
                        gnt       <= N_REQ'(1) << sel;
                        busy      <= 1'b1;
                        act_reset <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    act_reset <= 1'b0;
                    act_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    act_start <= 1'b0;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A real end pulse takes priority over a simultaneous timeout.
                    if (act_end) begin
                        y_out <= act_y;
                        err   <= 1'b0;
                        done  <= gnt;
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        y_out     <= '0;
                        err       <= 1'b1;
                        done      <= gnt;
                        act_reset <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= '0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    act_reset <= 1'b0;
                    ptr       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed bench for activation_arbiter; a small behavioural stand-in for the activation unit
// answers each start strobe after a programmable delay with a fixed transform of act_x.
module tb_activation_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] x_in = '0;
    logic [3:0]   gnt, done;
    logic [31:0]  y_out, act_x, act_y;
    logic         err, busy, act_start, act_reset, act_end;

    logic         act_end_m, act_end_i = 1'b0;
    logic [31:0]  act_y_m, act_y_i = '0;
    int           latency = 40;
    bit           model_en = 1'b1;
    int           m_cnt;
    bit           m_run;

    int checks = 0;
    int failures = 0;

    assign act_end = act_end_m | act_end_i;
    assign act_y   = act_end_i ? act_y_i : act_y_m;

    activation_arbiter #(.N_REQ(4), .WIDTH(32), .TIMEOUT(128)) dut (
        .clk(clk), .reset(reset), .req(req), .x_in(x_in), .gnt(gnt), .done(done),
        .y_out(y_out), .err(err), .busy(busy), .act_x(act_x), .act_start(act_start),
        .act_reset(act_reset), .act_y(act_y), .act_end(act_end)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] unit_f(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Stand-in unit: end pulse `latency` edges after the start strobe is seen.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run     <= 1'b0;
            m_cnt     <= 0;
            act_end_m <= 1'b0;
            act_y_m   <= '0;
        end else begin
            act_end_m <= 1'b0;
            if (act_start) begin
                m_run <= 1'b1;
                m_cnt <= latency;
            end else if (m_run) begin
                if (m_cnt <= 1) begin
                    m_run     <= 1'b0;
                    act_end_m <= model_en;
                    act_y_m   <= unit_f(act_x);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!act_start && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!act_start) cyc = -1;
    endtask

    task automatic wait_done(output int cyc, output int starts);
        cyc = 0;
        starts = 0;
        while (done == 4'b0000 && cyc < 400) begin
            tick();
            cyc++;
            if (act_start) starts++;
        end
        if (done == 4'b0000) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        tick();
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (y_out !== 32'h0) begin failures++; $display("FAIL reset_y: got %h want 0", y_out); end
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_err_busy: got %b%b want 00", err, busy); end
        checks++; if (act_x !== 32'h0 || act_start !== 1'b0) begin failures++; $display("FAIL reset_act: got x=%h start=%b want 0 0", act_x, act_start); end
        checks++; if (act_reset !== 1'b1) begin failures++; $display("FAIL reset_act_reset: got %b want 1", act_reset); end
        reset = 1'b1;
        #1;
        checks++; if (act_reset !== 1'b1) begin failures++; $display("FAIL release_act_reset: got %b want 1", act_reset); end
        tick();
        checks++; if (act_reset !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_release: got ar=%b busy=%b want 0 0", act_reset, busy); end
    endtask

    task automatic test_single();
        int cyc, starts;
        x_in[31:0] = 32'h0000_0100;
        latency = 40;
        model_en = 1'b1;
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        checks++; if (busy !== 1'b1 || act_reset !== 1'b1 || act_start !== 1'b0) begin failures++; $display("FAIL single_clear: got busy=%b ar=%b st=%b want 1 1 0", busy, act_reset, act_start); end
        checks++; if (act_x !== 32'h0000_0100) begin failures++; $display("FAIL single_act_x: got %h want 00000100", act_x); end
        x_in[31:0] = 32'hFFFF_FFFF;
        tick();
        checks++; if (act_start !== 1'b1 || act_reset !== 1'b0) begin failures++; $display("FAIL single_start: got st=%b ar=%b want 1 0", act_start, act_reset); end
        wait_done(cyc, starts);
        checks++; if (cyc !== 42) begin failures++; $display("FAIL single_latency: got %0d want 42", cyc); end
        checks++; if (done !== 4'b0001 || gnt !== 4'b0001) begin failures++; $display("FAIL single_done: got done=%b gnt=%b want 0001 0001", done, gnt); end
        checks++; if (y_out !== unit_f(32'h0000_0100) || err !== 1'b0) begin failures++; $display("FAIL single_y: got %h err=%b want %h 0", y_out, err, unit_f(32'h0000_0100)); end
        checks++; if (starts !== 0) begin failures++; $display("FAIL single_one_start: got %0d extra want 0", starts); end
        req = '0;
        tick();
        checks++; if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_exit: got done=%b gnt=%b busy=%b want 0000 0000 0", done, gnt, busy); end
        checks++; if (y_out !== unit_f(32'h0000_0100)) begin failures++; $display("FAIL single_hold: got %h want %h", y_out, unit_f(32'h0000_0100)); end
    endtask

    task automatic test_round_robin();
        int cyc, starts;
        logic [3:0] exp_d;
        do_reset();
        x_in = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        latency = 3;
        for (int pass = 0; pass < 2; pass++) begin
            req = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                exp_d = 4'b0001 << i;
                wait_done(cyc, starts);
                checks++; if (done !== exp_d) begin failures++; $display("FAIL rr_order p%0d i%0d: got %b want %b", pass, i, done, exp_d); end
                checks++; if (y_out !== unit_f(x_in[i*32 +: 32])) begin failures++; $display("FAIL rr_y p%0d i%0d: got %h want %h", pass, i, y_out, unit_f(x_in[i*32 +: 32])); end
                req[i] = 1'b0;
                tick();
                checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rr_pulse p%0d i%0d: got %b want 0000", pass, i, done); end
            end
        end
    endtask

    task automatic test_fairness();
        int cyc, starts;
        latency = 6;
        req = 4'b0001;
        wait_start(cyc);
        checks++; if (cyc < 0) begin failures++; $display("FAIL fair_start: got no start want start"); end
        tick();
        tick();
        req[2] = 1'b1;
        wait_done(cyc, starts);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL fair_first: got %b want 0001", done); end
        wait_done(cyc, starts);
        if (done !== 4'b0000) wait_done(cyc, starts);
        tick();
        wait_done(cyc, starts);
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL fair_second: got %b want 0100", done); end
        req[2] = 1'b0;
        tick();
        wait_done(cyc, starts);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL fair_third: got %b want 0001", done); end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc, starts;
        model_en = 1'b0;
        req = 4'b0010;
        wait_start(cyc);
        wait_done(cyc, starts);
        checks++; if (cyc !== 129) begin failures++; $display("FAIL tmo_latency: got %0d want 129", cyc); end
        checks++; if (done !== 4'b0010 || err !== 1'b1) begin failures++; $display("FAIL tmo_done: got done=%b err=%b want 0010 1", done, err); end
        checks++; if (y_out !== 32'h0 || act_reset !== 1'b1) begin failures++; $display("FAIL tmo_y_ar: got y=%h ar=%b want 0 1", y_out, act_reset); end
        req = '0;
        tick();
        checks++; if (act_reset !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL tmo_exit: got ar=%b err=%b want 0 1", act_reset, err); end
        model_en = 1'b1;
        req = 4'b0100;
        wait_done(cyc, starts);
        checks++; if (done !== 4'b0100 || err !== 1'b0 || act_reset !== 1'b0) begin failures++; $display("FAIL tmo_recover: got done=%b err=%b ar=%b want 0100 0 0", done, err, act_reset); end
        checks++; if (y_out !== unit_f(x_in[95:64])) begin failures++; $display("FAIL tmo_recover_y: got %h want %h", y_out, unit_f(x_in[95:64])); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, starts;
        latency = 40;
        req = 4'b1000;
        wait_start(cyc);
        repeat (10) tick();
        checks++; if (busy !== 1'b1 || gnt !== 4'b1000) begin failures++; $display("FAIL mid_busy: got busy=%b gnt=%b want 1 1000", busy, gnt); end
        reset = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || act_reset !== 1'b1) begin failures++; $display("FAIL mid_async: got gnt=%b busy=%b ar=%b want 0000 0 1", gnt, busy, act_reset); end
        req = 4'b1010;
        tick();
        tick();
        checks++; if (done !== 4'b0000 || gnt !== 4'b0000) begin failures++; $display("FAIL mid_held: got done=%b gnt=%b want 0000 0000", done, gnt); end
        reset = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_ptr0: got %b want 0010", gnt); end
        wait_done(cyc, starts);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL mid_serve1: got %b want 0010", done); end
        req[1] = 1'b0;
        tick();
        wait_done(cyc, starts);
        checks++; if (done !== 4'b1000) begin failures++; $display("FAIL mid_serve3: got %b want 1000", done); end
        req = '0;
        tick();
    endtask

    task automatic test_act_end_ignored();
        int cyc;
        act_y_i = 32'hDEAD_BEEF;
        act_end_i = 1'b1;
        tick();
        act_end_i = 1'b0;
        checks++; if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL idle_end: got done=%b busy=%b gnt=%b want 0000 0 0000", done, busy, gnt); end
        checks++; if (y_out !== unit_f(x_in[127:96]) || err !== 1'b0) begin failures++; $display("FAIL idle_end_hold: got %h err=%b want %h 0", y_out, err, unit_f(x_in[127:96])); end
        model_en = 1'b0;
        req = 4'b0001;
        wait_start(cyc);
        repeat (128) tick();
        checks++; if (done !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL coinc_pre: got done=%b busy=%b want 0000 1", done, busy); end
        act_y_i = 32'hCAFE_F00D;
        act_end_i = 1'b1;
        tick();
        act_end_i = 1'b0;
        checks++; if (done !== 4'b0001 || err !== 1'b0) begin failures++; $display("FAIL coinc_done: got done=%b err=%b want 0001 0", done, err); end
        checks++; if (y_out !== 32'hCAFE_F00D) begin failures++; $display("FAIL coinc_y: got %h want cafef00d", y_out); end
        req = '0;
        model_en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_act_end_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
